boolean_minterm_scanner: RTL and testbench
==========================================

# boolean_minterm_scanner

Sequential truth-table enumerator for the team's two fixed 4-input boolean functions F1 and F2. On a start request it walks all 16 input codes, evaluates the selected function at each, streams the indices of true minterms over a valid/ready interface, and reports the full 16-bit truth-table mask and minterm count. It is the decode direction of the combinational boolean block: function in, minterm list out. Used by self-test and by software readback of the implemented functions.

## Interface
- SCAN_DESC, default 0: 0 = scan index 0→15; 1 = scan 15→0.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  scan request; accepted only in IDLE.
- sel  input  1  0 = F1, 1 = F2; sampled when start is accepted.
- busy  output  1  high in SCAN and DONE.
- m_valid  output  1  minterm index valid.
- m_idx  output  4  minterm index {MSB..LSB} = {A,B,C,D} for F1, {w,x,y,z} for F2.
- m_ready  input  1  sink accepts m_idx.
- done  output  1  one-cycle pulse; mask and count final.
- mask  output  16  bit i = function value at index i.
- count  output  5  number of true minterms (0..16).

## Operation
- Functions, fixed:
  - F1 = ~A~B~C~D | A~C~D | ~BC~D | ~ABCD | B~CD. Minterms 0,2,5,7,8,10,12,13; mask 0x35A5.
  - F2 = x~yz | ~x~yz | ~wxy | wx~y | wxy. Minterms 1,5,6,7,9,12,13,14,15; mask 0xF2E2.
- FSM states:
  - IDLE: start=1 → latch sel, clear mask and count, load idx (0, or 15 if SCAN_DESC) → SCAN.
  - SCAN: evaluate f(idx).
    - If false: set mask[idx]=0 and advance.
    - If true: assert m_valid with m_idx=idx; on m_valid&m_ready set mask[idx]=1, increment count and advance.
    - Advancing from the last index (15, or 0 if SCAN_DESC) → DONE.
  - DONE: done=1 for one cycle → IDLE.
- m_valid is derived only from the state, the latched sel and the idx register. No dependency on m_ready (no combinational ready→valid path).
- Once asserted, m_valid and m_idx are held stable until the handshake.
- start is ignored while busy. sel changes after acceptance have no effect.
- mask and count hold their values after DONE until the next accepted start.
- idx is 4 bits; the terminal index is detected explicitly, not by wrap.

## Timing
- Reset values: state IDLE, busy=0, m_valid=0, m_idx=0, done=0, mask=0, count=0.
- Reset asserted mid-scan: immediate return to all reset values. No done pulse. The partial mask is discarded.
- Start accepted at edge N: busy=1 and the first index is presented after edge N.
- With m_ready held high: exactly 16 cycles in SCAN, done high in the cycle after the 16th evaluation (edge N+17), busy low after edge N+18.
- Each cycle of m_ready=0 while m_valid=1 adds one stall cycle. False minterms never stall.
- Earliest back-to-back start: the cycle busy returns low.

## Configuration
- BOOL_SCAN_STREAM_EN defined: the minterm stream is present as described above.
- BOOL_SCAN_STREAM_EN undefined:
  - m_valid and m_idx are tied to 0, and m_ready is ignored.
  - True minterms advance unconditionally, so a scan is always 16 cycles.
  - mask, count, done and busy behave identically.

## Test plan
- sel=0, m_ready=1, SCAN_DESC=0 → m_idx stream 0,2,5,7,8,10,12,13; mask=0x35A5; count=8; done at edge N+17.
- sel=1, m_ready=1 → stream 1,5,6,7,9,12,13,14,15; mask=0xF2E2; count=9.
- sel=1, m_ready low 3 cycles at index 6 → m_idx=6 held stable with m_valid=1; done delayed by exactly 3 cycles; mask unchanged.
- start pulsed at SCAN cycle 4 and sel toggled mid-scan → no restart; result equals the sel latched at acceptance.
- rst_n low at SCAN cycle 7 → all outputs 0 asynchronously; no done; a fresh scan then completes with the correct mask.
- SCAN_DESC=1, sel=0 → stream 13,12,10,8,7,5,2,0; mask 0x35A5. Build without BOOL_SCAN_STREAM_EN → m_valid never asserts; done at N+17 with m_ready=0.

Source files
------------

// File: rtl/boolean_minterm_scanner.sv
// boolean_minterm_scanner: walks all 16 input codes of F1/F2, streams the
// indices of true minterms over valid/ready and reports truth-table mask and
// minterm count. Optional stream enabled by macro BOOL_SCAN_STREAM_EN; when
// undefined m_valid/m_idx are tied low and every scan takes 16 cycles.
module boolean_minterm_scanner #(
  parameter bit SCAN_DESC = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sel,
  output logic        busy,
  output logic        m_valid,
  output logic [3:0]  m_idx,
  input  logic        m_ready,
  output logic        done,
  output logic [15:0] mask,
  output logic [4:0]  count
);

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned N_CODES = 16;
  localparam logic [IDX_W-1:0] FIRST_IDX = SCAN_DESC ? IDX_W'(15) : IDX_W'(0);
  localparam logic [IDX_W-1:0] LAST_IDX  = SCAN_DESC ? IDX_W'(0)  : IDX_W'(15);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               sel_q, sel_n;
  logic [N_CODES-1:0] mask_n;
  logic [CNT_W-1:0]   count_n;
  logic               busy_n, done_n;
  logic               f_cur, hs_ok, advance;

  // Fixed functions; index bits are {A,B,C,D} for F1 and {w,x,y,z} for F2.
  function automatic logic eval_fn(input logic s, input logic [IDX_W-1:0] i);
    logic a, b, c, d;
    {a, b, c, d} = i;
    if (!s) return (~a & ~b & ~c & ~d) | (a & ~c & ~d) | (~b & c & ~d) |
                   (~a & b & c & d) | (b & ~c & d);
    else    return (b & ~c & d) | (~b & ~c & d) | (~a & b & c) |
                   (a & b & ~c) | (a & b & c);
  endfunction

`ifdef BOOL_SCAN_STREAM_EN
  assign hs_ok = m_ready;
`else
  // No stream: true minterms never wait for the sink.
  assign hs_ok = 1'b1 | m_ready;
`endif

  // Next-state, scan bookkeeping and registered-output next values.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sel_n   = sel_q;
    mask_n  = mask;
    count_n = count;
    busy_n  = 1'b1;
    done_n  = 1'b0;
    advance = 1'b0;
    f_cur   = eval_fn(sel_q, idx);
    case (state)
      ST_IDLE: begin
        busy_n = 1'b0;
        // busy still high in the cycle after done: start not yet accepted.
        if (start && !busy) begin
          state_n = ST_SCAN;
          sel_n   = sel;
          mask_n  = '0;
          count_n = '0;
          idx_n   = FIRST_IDX;
          busy_n  = 1'b1;
        end
      end
      ST_SCAN: begin
        advance = !f_cur || hs_ok;
        if (advance) begin
          mask_n[idx] = f_cur;
          count_n     = count + CNT_W'(f_cur);
          if (idx == LAST_IDX) state_n = ST_DONE;
          else                 idx_n   = SCAN_DESC ? idx - IDX_W'(1) : idx + IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      sel_q <= 1'b0;
      mask  <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      sel_q <= sel_n;
      mask  <= mask_n;
      count <= count_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

`ifdef BOOL_SCAN_STREAM_EN
  logic             valid_n;
  logic [IDX_W-1:0] m_idx_n;

  // Stream next values depend only on next state, latched sel and next idx.
  always_comb begin
    valid_n = (state_n == ST_SCAN) && eval_fn(sel_n, idx_n);
    m_idx_n = valid_n ? idx_n : '0;
  end

  // Registered minterm stream; held until the handshake advances idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_idx   <= '0;
    end else begin
      m_valid <= valid_n;
      m_idx   <= m_idx_n;
    end
  end
`else
  assign m_valid = 1'b0;
  assign m_idx   = '0;
`endif

endmodule

// File: tb/tb_boolean_minterm_scanner.sv
// Self-checking bench for boolean_minterm_scanner: randomized and directed
// scans checked cycle by cycle against a truth-table reference model.
`timescale 1ns/1ps
module tb_boolean_minterm_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic m_ready = 1'b0;
  logic use_desc = 1'b0;

  logic        a_busy, a_valid, a_done, d_busy, d_valid, d_done;
  logic [3:0]  a_idx, d_idx;
  logic [15:0] a_mask, d_mask;
  logic [4:0]  a_count, d_count;

  logic        o_busy, o_valid, o_done;
  logic [3:0]  o_idx;
  logic [15:0] o_mask;
  logic [4:0]  o_count;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef BOOL_SCAN_STREAM_EN
  localparam bit STREAM = 1'b1;
`else
  localparam bit STREAM = 1'b0;
`endif

  boolean_minterm_scanner #(.SCAN_DESC(1'b0)) dut_asc (
    .clk(clk), .rst_n(rst_n), .start(start & ~use_desc), .sel(sel),
    .busy(a_busy), .m_valid(a_valid), .m_idx(a_idx), .m_ready(m_ready),
    .done(a_done), .mask(a_mask), .count(a_count)
  );

  boolean_minterm_scanner #(.SCAN_DESC(1'b1)) dut_desc (
    .clk(clk), .rst_n(rst_n), .start(start & use_desc), .sel(sel),
    .busy(d_busy), .m_valid(d_valid), .m_idx(d_idx), .m_ready(m_ready),
    .done(d_done), .mask(d_mask), .count(d_count)
  );

  assign o_busy  = use_desc ? d_busy  : a_busy;
  assign o_valid = use_desc ? d_valid : a_valid;
  assign o_done  = use_desc ? d_done  : a_done;
  assign o_idx   = use_desc ? d_idx   : a_idx;
  assign o_mask  = use_desc ? d_mask  : a_mask;
  assign o_count = use_desc ? d_count : a_count;

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  16'(o_busy),  16'h0);
    chk({tag, "_valid"}, 16'(o_valid), 16'h0);
    chk({tag, "_idx"},   16'(o_idx),   16'h0);
    chk({tag, "_done"},  16'(o_done),  16'h0);
    chk({tag, "_mask"},  o_mask,       16'h0);
    chk({tag, "_count"}, 16'(o_count), 16'h0);
  endtask

  // mode: 0 ready high, 1 random ready, 2 three stalls at index 6,
  // 3 ready mostly low. poke: SCAN cycle at which start is re-pulsed and sel flipped.
  task automatic run_scan(input bit desc, input bit s, input int mode, input int poke);
    logic [15:0] tt;
    logic [3:0]  cur;
    int          pos;
    int          stalls6;
    bit          ev;
    bit          stall;
    tt = s ? 16'hF2E2 : 16'h35A5;
    use_desc = desc;
    sel = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pos = 0;
    stalls6 = 0;
    for (int k = 0; k < 400 && pos < 16; k++) begin
      cur = desc ? 4'(15 - pos) : 4'(pos);
      ev  = STREAM && tt[cur];
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        2:       m_ready = !(cur == 4'd6 && stalls6 < 3);
        default: m_ready = (k % 5 == 4);
      endcase
      if (k == poke) begin
        start = 1'b1;
        sel = ~sel;
      end else begin
        start = 1'b0;
      end
      chk("scan_busy", 16'(o_busy), 16'h1);
      chk("scan_done", 16'(o_done), 16'h0);
      chk("m_valid", 16'(o_valid), 16'(ev));
      if (ev) chk("m_idx", 16'(o_idx), 16'(cur));
      stall = ev && !m_ready;
      if (stall && cur == 4'd6) stalls6++;
      if (!stall) pos++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("scan_complete", 16'(pos), 16'd16);
    chk("lastcyc_done", 16'(o_done), 16'h0);
    chk("lastcyc_busy", 16'(o_busy), 16'h1);
    chk("lastcyc_valid", 16'(o_valid), 16'h0);
    @(posedge clk); #1;
    chk("done_pulse", 16'(o_done), 16'h1);
    chk("done_busy", 16'(o_busy), 16'h1);
    chk("done_mask", o_mask, tt);
    chk("done_count", 16'(o_count), 16'($countones(tt)));
    @(posedge clk); #1;
    chk("post_done", 16'(o_done), 16'h0);
    chk("post_busy", 16'(o_busy), 16'h0);
    chk("hold_mask", o_mask, tt);
    chk("hold_count", 16'(o_count), 16'($countones(tt)));
  endtask

  initial begin
    // Reset state of both instances.
    #1;
    use_desc = 1'b0;
    #1;
    chk_all_zero("reset_asc");
    use_desc = 1'b1;
    #1;
    chk_all_zero("reset_desc");
    use_desc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("idle_asc");

    // F1 then F2 back to back, ascending, sink always ready.
    run_scan(1'b0, 1'b0, 0, -1);
    run_scan(1'b0, 1'b1, 0, -1);

    // F2 with three stall cycles at index 6.
    run_scan(1'b0, 1'b1, 2, -1);

    // Start re-pulsed and sel flipped during the scan.
    run_scan(1'b0, 1'b0, 0, 4);

    // Asynchronous reset mid-scan, then a fresh scan.
    use_desc = 1'b0;
    sel = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_ready = 1'b1;
    repeat (7) @(posedge clk);
    #3;
    chk("pre_reset_busy", 16'(o_busy), 16'h1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (3) begin
      @(posedge clk); #1;
      chk("in_reset_done", 16'(o_done), 16'h0);
      chk("in_reset_busy", 16'(o_busy), 16'h0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("after_reset_done", 16'(o_done), 16'h0);
      chk("after_reset_mask", o_mask, 16'h0);
    end
    run_scan(1'b0, 1'b1, 0, -1);

    // Descending scan of F1.
    run_scan(1'b1, 1'b0, 0, -1);

    // Sink mostly not ready.
    run_scan(1'b0, 1'b1, 3, -1);
    run_scan(1'b1, 1'b1, 3, -1);

    // Randomized scans.
    for (int r = 0; r < 6; r++) begin
      run_scan(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
